// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector (1..MAX_LEN bits, overlap selectable) with saturating match counter.
// Latency: one cycle from the completing accepted bit to seq_seen; no backpressure, a bit is taken whenever inp_valid is high.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    localparam int LW1 = LW + 1;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ov_q, ov_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               match;
    logic               fill_ok;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;

    always_comb begin
        accept     = inp_valid && !cfg_we;
        hist_shift = {hist_q[MAX_LEN-2:0], inp_bit};
        len_mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        // Extra bit so fill+1 cannot wrap when MAX_LEN+1 is a power of two.
        fill_ok = ({1'b0, fill_q} + LW1'(1)) >= {1'b0, len_q};
        match   = accept && (len_q != '0) && fill_ok &&
                  (((hist_shift ^ pat_q) & len_mask) == '0);

        pat_d  = pat_q;
        len_d  = len_q;
        ov_d   = ov_q;
        hist_d = hist_q;
        fill_d = fill_q;
        seen_d = match;
        cnt_d  = cnt_q;

        if (cfg_we) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
            ov_d   = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            if (match && !ov_q) begin
                fill_d = '0;
            end else if (fill_q != LW'(MAX_LEN)) begin
                fill_d = fill_q + LW'(1);
            end
        end

        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= MAX_LEN'(4'b1011);
            len_q  <= LW'(4);
            ov_q   <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ov_q   <= ov_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    assign seq_seen    = seen_q;
    assign match_count = cnt_q;
    assign cnt_sat     = &cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a default instance and a 2-bit-counter instance share all inputs.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       inp_valid;
    logic       inp_bit;
    logic       cnt_clr;

    logic       seen1, seen2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;
    logic       sat1, sat2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp_valid(inp_valid),
        .inp_bit(inp_bit), .cnt_clr(cnt_clr), .seq_seen(seen1),
        .match_count(cnt1), .cnt_sat(sat1)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp_valid(inp_valid),
        .inp_bit(inp_bit), .cnt_clr(cnt_clr), .seq_seen(seen2),
        .match_count(cnt2), .cnt_sat(sat2)
    );

    task automatic drive(input logic v, input logic b);
        inp_valid = v;
        inp_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_we      = 1'b1;
        cnt_clr     = 1'b1;
        drive(1'b0, 1'b0);
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
        checks++;
        if (seen1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL load_state: seen=%b cnt=%0d, expected seen=0 cnt=0", seen1, cnt1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cfg_we = 1'b1;
        cnt_clr = 1'b1;
        cfg_pattern = 8'h00;
        cfg_len = 4'd1;
        cfg_overlap = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (seen1 !== 1'b0 || cnt1 !== 8'd0 || sat1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: seen=%b cnt=%0d sat=%b, expected 0 0 0", seen1, cnt1, sat1);
        end
        checks++;
        if (seen2 !== 1'b0 || cnt2 !== 2'd0 || sat2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: seen=%b cnt=%0d sat=%b, expected 0 0 0", seen2, cnt2, sat2);
        end
        reset = 1'b0;
        cfg_we = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_default;
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            checks++;
            if (seen1 !== exp[i]) begin
                errors++;
                $display("FAIL default_bit%0d: seen=%b expected %b", 7 - i, seen1, exp[i]);
            end
        end
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL default_count: cnt=%0d expected 1", cnt1);
        end
    endtask

    task automatic test_overlap;
        logic [4:0] bits  = 5'b10101;
        logic [4:0] exp_o = 5'b00101;
        logic [4:0] exp_n = 5'b00100;
        load(8'b101, 4'd3, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            checks++;
            if (seen1 !== exp_o[i]) begin
                errors++;
                $display("FAIL overlap_bit%0d: seen=%b expected %b", 5 - i, seen1, exp_o[i]);
            end
        end
        checks++;
        if (cnt1 !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count: cnt=%0d expected 2", cnt1);
        end
        load(8'b101, 4'd3, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            checks++;
            if (seen1 !== exp_n[i]) begin
                errors++;
                $display("FAIL nonoverlap_bit%0d: seen=%b expected %b", 5 - i, seen1, exp_n[i]);
            end
        end
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_count: cnt=%0d expected 1", cnt1);
        end
    endtask

    task automatic test_gaps;
        logic [3:0] bits = 4'b1011;
        load(8'b1011, 4'd4, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            checks++;
            if (seen1 !== (i == 0)) begin
                errors++;
                $display("FAIL gap_bit%0d: seen=%b expected %b", 4 - i, seen1, (i == 0));
            end
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, ~bits[i]);
                checks++;
                if (seen1 !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_idle%0d_%0d: seen=%b expected 0", 4 - i, g, seen1);
                end
            end
        end
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL gap_count: cnt=%0d expected 1", cnt1);
        end
    endtask

    task automatic test_saturate;
        logic [1:0] exp2;
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1);
            exp2 = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++;
            if (cnt2 !== exp2 || sat2 !== (i >= 2) || seen2 !== 1'b1) begin
                errors++;
                $display("FAIL sat_step%0d: cnt=%0d sat=%b seen=%b expected cnt=%0d sat=%b seen=1",
                         i + 1, cnt2, sat2, seen2, exp2, (i >= 2));
            end
            checks++;
            if (cnt1 !== 8'(i + 1) || sat1 !== 1'b0) begin
                errors++;
                $display("FAIL wide_step%0d: cnt=%0d sat=%b expected cnt=%0d sat=0", i + 1, cnt1, sat1, i + 1);
            end
        end
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1);
        checks++;
        if (cnt1 !== 8'd1 || cnt2 !== 2'd1 || sat2 !== 1'b0 || seen1 !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_match: cnt1=%0d cnt2=%0d sat2=%b seen=%b expected 1 1 0 1", cnt1, cnt2, sat2, seen1);
        end
        drive(1'b0, 1'b0);
        cnt_clr = 1'b0;
        checks++;
        if (cnt1 !== 8'd0 || cnt2 !== 2'd0 || seen1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone: cnt1=%0d cnt2=%0d seen=%b expected 0 0 0", cnt1, cnt2, seen1);
        end
    endtask

    task automatic test_discard;
        logic [3:0] post = 4'b1011;
        load(8'b1011, 4'd4, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        cfg_we = 1'b1;
        drive(1'b1, 1'b1);
        cfg_we = 1'b0;
        checks++;
        if (seen1 !== 1'b0) begin
            errors++;
            $display("FAIL cfg_same_cycle: seen=%b expected 0", seen1);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (seen1 !== 1'b0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL cfg_after: seen=%b cnt=%0d expected 0 0", seen1, cnt1);
        end
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        reset = 1'b1;
        drive(1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (seen1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: seen=%b expected 0", seen1);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, post[i]);
            checks++;
            if (seen1 !== (i == 0)) begin
                errors++;
                $display("FAIL post_reset_bit%0d: seen=%b expected %b", 4 - i, seen1, (i == 0));
            end
        end
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_count: cnt=%0d expected 1", cnt1);
        end
    endtask

    task automatic test_length;
        load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (seen1 !== 1'b0) begin
                errors++;
                $display("FAIL len0_bit%0d: seen=%b expected 0", i + 1, seen1);
            end
        end
        load(8'hFF, 4'd15, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1);
            checks++;
            if (seen1 !== (i == 7)) begin
                errors++;
                $display("FAIL len15_bit%0d: seen=%b expected %b", i + 1, seen1, (i == 7));
            end
        end
        checks++;
        if (cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL len15_count: cnt=%0d expected 1", cnt1);
        end
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len = 4'd0;
        cfg_overlap = 1'b0;
        inp_valid = 1'b0;
        inp_bit = 1'b0;
        cnt_clr = 1'b0;
        test_reset();
        test_default();
        test_overlap();
        test_gaps();
        test_saturate();
        test_discard();
        test_length();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector with a runtime-loadable pattern of 1 to MAX_LEN bits, selectable overlapping or non-overlapping detection, a one-cycle detection pulse and a saturating match counter. It sits on a single-bit serial input stream in the same clock domain as the surrounding detectors. It generalises the fixed 4-bit detector: out of reset it detects 1011 in non-overlapping mode, and software can reprogram it without a reset.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥ 2).
- CNT_W, 8: match counter width.
- LW (derived), clog2(MAX_LEN+1): width of length fields.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration load strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping detection.
- inp_valid  in  1  inp_bit is sampled only when this is high.
- inp_bit  in  1  serial data.
- cnt_clr  in  1  synchronous clear of match_count.
- seq_seen  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  high while match_count is all ones.

## Operation
- State:
  - pattern register, length register, overlap register;
  - MAX_LEN-bit history shift register, where each accepted bit shifts in at bit 0;
  - fill counter (0..MAX_LEN) giving the number of valid history bits since the last clear.
- Accepted bit: inp_valid=1 and cfg_we=0 on a rising edge. In that case the history shifts and the fill counter increments, saturating at MAX_LEN.
- Match: an accepted bit, length register L ≥ 1, fill+1 ≥ L, and the new history[L-1:0] == pattern[L-1:0].
- On match:
  - seq_seen=1 on the next cycle.
  - match_count increments, unless it is saturated.
  - Overlap=1: history and fill are kept, so suffixes count toward the next match.
  - Overlap=0: the fill counter clears to 0 after the match bit is taken into history. The next match therefore needs L fresh bits.
- Config load (cfg_we=1):
  - The pattern, length and overlap registers take the cfg_* inputs.
  - History and fill clear to 0.
  - inp_bit in the same cycle is discarded, and no match is possible that cycle.
  - match_count is unaffected.
- Length rules: cfg_len > MAX_LEN is stored as MAX_LEN. cfg_len=0 disables detection: no matches, though bits are still shifted.
- Counter:
  - cnt_clr=1 sets match_count to 0, or to 1 if a match occurs in the same cycle.
  - Once match_count reaches 2^CNT_W−1 it holds there.
  - cnt_sat = (match_count == all ones), combinational from the register.
- Reset sets: pattern = 1011 in bits [3:0] with zeros above, length 4, overlap 0, history 0, fill 0, seq_seen 0, match_count 0. Reset overrides cfg_we and cnt_clr.

## Timing
- Latency is 1 cycle: the edge that accepts the completing bit registers seq_seen=1, and it is visible for exactly that one following cycle.
- Back-to-back matches in overlap mode produce consecutive seq_seen pulses; for example pattern 11, L=2 with input 1111 pulses on bits 2, 3 and 4.
- inp_valid=0 cycles leave history, fill and counter frozen, and seq_seen is 0 in the following cycle.
- Reset asserted mid-stream: on the next edge all state returns to reset values and any pending partial match is lost. The first bit accepted after reset deasserts is bit 1 of a new stream.
- A new configuration applies to the first accepted bit after the cfg_we edge.

## Test plan
- Reset defaults, stream 1,0,1,1,0,1,1 with valid always high -> seq_seen pulses only after bit 4 (non-overlap: the trailing 011 does not match); match_count=1.
- Load pattern 0b101, L=3, overlap=1, then stream 1,0,1,0,1 -> pulses after bits 3 and 5; match_count=2. Same stream with overlap=0 -> one pulse after bit 3, match_count=1.
- Default pattern, stream 1,0,1,1 with inp_valid low for 2 cycles between each bit -> a single pulse one cycle after the 4th accepted bit; no pulses during gaps.
- CNT_W=2, overlap=1, L=1, pattern 1, 5 consecutive 1s -> match_count 1,2,3,3,3; cnt_sat high from the 3rd match on. cnt_clr asserted together with a match -> match_count=1.
- Stream 1,0,1, then cfg_we (same config) together with inp_bit=1, then 1 -> no match. Reset asserted after 1,0,1, then 1 -> no match.
- cfg_len=0 -> no matches for any stream. cfg_len=15 with MAX_LEN=8 and pattern 0xFF -> pulse after 8 ones.
